// File: rtl/fir_mac_engine.sv
// -----------------------------------------------------------------------------
// fir_mac_engine
//
// Time-multiplexed FIR filter built around a single multiply-accumulate unit.
// One signed sample is accepted per input handshake. The engine then walks all
// TAPS coefficients, one tap per clock, and computes
//     y[n] = sum_k h[k] * x[n-k]
// at full precision before offering the result on a valid/ready output.
//
// The delay line is a circular buffer addressed by the write pointer wp. The
// newest sample sits at x[wp], and tap k reads x[(wp - k) mod TAPS].
//
// Ports
//   S_AXI_ACLK    in   clock, all state updates on the rising edge
//   S_AXI_ARESET  in   synchronous active-high reset
//   enable        in   level, allows sample acceptance while idle
//   clear         in   level, zeroes delay line and write pointer while idle
//   coef_wr       in   coefficient write strobe (honoured only while idle)
//   coef_addr     in   tap index for the coefficient write
//   coef_data     in   signed coefficient value
//   s_valid       in   input sample valid
//   s_data        in   signed input sample
//   s_ready       out  engine can accept a sample this cycle
//   m_valid       out  result valid
//   m_data        out  signed full-precision result, held while stalled
//   m_ready       in   downstream accepts the result
//   busy          out  engine is accumulating or holding a result
// -----------------------------------------------------------------------------
module fir_mac_engine #(
    parameter int DATA_WIDTH     = 16,
    parameter int FIR_ADDR_WIDTH = 6
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESET,
    input  logic                                     enable,
    input  logic                                     clear,
    input  logic                                     coef_wr,
    input  logic [FIR_ADDR_WIDTH-1:0]                coef_addr,
    input  logic [DATA_WIDTH-1:0]                    coef_data,
    input  logic                                     s_valid,
    input  logic [DATA_WIDTH-1:0]                    s_data,
    output logic                                     s_ready,
    output logic                                     m_valid,
    output logic [2*DATA_WIDTH+FIR_ADDR_WIDTH-1:0]   m_data,
    input  logic                                     m_ready,
    output logic                                     busy
);

    localparam int TAPS       = 2 ** FIR_ADDR_WIDTH;
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int ACC_WIDTH  = PROD_WIDTH + FIR_ADDR_WIDTH;

    localparam logic [FIR_ADDR_WIDTH-1:0] KLast = FIR_ADDR_WIDTH'(TAPS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StOut
    } state_e;

    state_e state_q, state_d;

    // Storage
    logic [DATA_WIDTH-1:0]       coef_q [TAPS];
    logic [DATA_WIDTH-1:0]       hist_q [TAPS];
    logic [FIR_ADDR_WIDTH-1:0]   wp_q;
    logic [FIR_ADDR_WIDTH-1:0]   k_q;
    logic signed [ACC_WIDTH-1:0] acc_q;

    // Control decode
    logic in_idle;
    logic in_mac;
    logic accept;
    logic coef_we;
    logic clear_idle;
    logic mac_done;

    // Datapath
    logic [FIR_ADDR_WIDTH-1:0]    rd_idx;
    logic [DATA_WIDTH-1:0]        coef_sel;
    logic [DATA_WIDTH-1:0]        hist_sel;
    logic signed [PROD_WIDTH-1:0] coef_ext;
    logic signed [PROD_WIDTH-1:0] hist_ext;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]  product_ext;

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    assign in_idle    = (state_q == StIdle);
    assign in_mac     = (state_q == StMac);
    assign accept     = s_valid & s_ready;
    assign coef_we    = in_idle & coef_wr;
    // clear is level-sensitive but only honoured once back in idle
    assign clear_idle = in_idle & clear;
    assign mac_done   = in_mac & (k_q == KLast);

    // -------------------------------------------------------------------------
    // MAC datapath
    // -------------------------------------------------------------------------
    // Unsigned subtraction wraps naturally modulo TAPS.
    assign rd_idx   = wp_q - k_q;
    assign coef_sel = coef_q[k_q];
    assign hist_sel = hist_q[rd_idx];

    // Sign-extend operands to product width so the multiply is carried out
    // at full width; the low PROD_WIDTH bits are the exact signed product.
    assign coef_ext = {{DATA_WIDTH{coef_sel[DATA_WIDTH-1]}}, coef_sel};
    assign hist_ext = {{DATA_WIDTH{hist_sel[DATA_WIDTH-1]}}, hist_sel};
    assign product  = coef_ext * hist_ext;

    // FIR_ADDR_WIDTH guard bits absorb the sum of TAPS worst-case products.
    assign product_ext = {{FIR_ADDR_WIDTH{product[PROD_WIDTH-1]}}, product};

    assign m_data = acc_q;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StMac;
                end
            end
            StMac: begin
                if (k_q == KLast) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                if (m_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // Reset gates the handshake outputs so nothing is offered or accepted
    // while the engine is being reset, whatever state it was in.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        busy    = 1'b0;
        if (!S_AXI_ARESET) begin
            unique case (state_q)
                StIdle: begin
                    s_ready = enable & ~clear;
                end
                StMac: begin
                    busy = 1'b1;
                end
                StOut: begin
                    m_valid = 1'b1;
                    busy    = 1'b1;
                end
                default: begin
                    s_ready = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Coefficient memory
    // -------------------------------------------------------------------------
    // Writes outside idle are dropped so a running accumulation always sees a
    // consistent coefficient set.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_we) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    // -------------------------------------------------------------------------
    // Delay line
    // -------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= '0;
            end
        end else if (clear_idle) begin
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= '0;
            end
        end else if (accept) begin
            hist_q[wp_q] <= s_data;
        end
    end

    // -------------------------------------------------------------------------
    // Write pointer
    // -------------------------------------------------------------------------
    // Advanced only once the whole sum is done, so every tap of a given sample
    // indexes relative to the slot that sample was written into.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wp_q <= '0;
        end else if (clear_idle) begin
            wp_q <= '0;
        end else if (mac_done) begin
            wp_q <= wp_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Tap counter and accumulator
    // -------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            k_q   <= '0;
            acc_q <= '0;
        end else if (accept) begin
            k_q   <= '0;
            acc_q <= '0;
        end else if (in_mac) begin
            // k wraps back to zero after the last tap
            k_q   <= k_q + 1'b1;
            acc_q <= acc_q + product_ext;
        end
    end

endmodule
